mux3_rr_arbiter: RTL and testbench
==================================

Name: mux3_rr_arbiter

Overview:
- Shares one Mux3to1 datapath between three requesters using a round-robin policy.
- Each requester presents data with a req/gnt handshake. The winner's data goes through an internal Mux3to1 (size = size) into an output register.
- A single downstream consumer drains the output register with a valid/ready handshake.
- Sits in front of any shared write-back or bus resource in the datapath.

Parameters:
size, 32, data width of every data port and of the internal Mux3to1.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req0_i  input  1  requester 0 request.
- req1_i  input  1  requester 1 request.
- req2_i  input  1  requester 2 request.
- data0_i  input  size  requester 0 data; must be stable while req0_i is high and not yet granted.
- data1_i  input  size  requester 1 data; same stability rule.
- data2_i  input  size  requester 2 data; same stability rule.
- gnt_o  output  3  one-hot grant pulse; bit n = requester n's data captured this edge.
- select_o  output  2  registered index of the last granted requester.
- valid_o  output  1  data_o holds an undelivered word.
- ready_i  input  1  consumer accepts data_o when valid_o is also high.
- data_o  output  size  registered output word.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset values: valid_o=0, data_o=0, gnt_o=3'b000, select_o=2'd2, state=IDLE. With last=2, the first arbitration priority is 0>1>2.
- Reset mid-operation: the pending word is discarded, and no gnt_o is issued for it.
- Winner (combinational): search order last+1, last+2, last+3 (mod 3), where last=select_o. The first asserted req wins. The winner index drives the internal Mux3to1 select_i; the value 2'd3 is never produced.
- capture = (state==IDLE && any req) || (state==BUSY && ready_i && any req).
- On a capture edge:
  - data_o <= mux output;
  - valid_o <= 1;
  - select_o <= winner;
  - gnt_o <= one-hot(winner) for exactly one cycle;
  - state <= BUSY.
- All cycles other than a capture edge: gnt_o=0.
- FSM transitions:
  - IDLE: no req -> stay IDLE, valid_o=0. Any req -> capture; BUSY next cycle.
  - BUSY, ready_i=0 -> hold data_o, valid_o, select_o. Requests wait, and no grant is issued.
  - BUSY, ready_i=1, no req -> word delivered; valid_o <= 0; IDLE.
  - BUSY, ready_i=1, any req -> word delivered and new winner captured on the same edge. This gives back-to-back throughput of 1 word/cycle.
- Latency: req high at edge k (IDLE) -> gnt_o and valid_o high after edge k, data_o valid in that cycle.
- Requester rule:
  - After seeing gnt bit n high, requester n either drops req or presents the next word.
  - req high with gnt low means still waiting.
- Fairness: with all three requesting continuously, grants rotate 0,1,2,0,... Any requester waits at most 2 grants.
- Simultaneous requests: resolved only by rotation; no fixed priority beyond the pointer.
- A request dropped before being granted is legal; no grant is issued for it.
- ready_i while valid_o=0 is ignored.

Test Plan:
- Reset then idle: rst_i pulse, no req for 5 cycles -> valid_o=0, gnt_o=000, select_o=2, data_o=0.
- Single request, size=8: req1_i=1, data1_i=8'h5A, ready_i=1 -> after the next edge gnt_o=010, select_o=1, valid_o=1, data_o=5A. Drop req -> valid_o=0 one cycle later.
- All three requesting continuously, data0/1/2 = 04/05/06, ready_i=1 -> grants 001,010,100,001,... every cycle; data_o sequence 04,05,06,04.
- Backpressure: req0 and req2 high, ready_i=0 for 4 cycles after the first grant (001) -> data_o=04 held, gnt_o=000, valid_o=1 throughout. ready_i=1 -> next edge gnt_o=100, data_o=06.
- Rotation after idle: grant requester 2, go idle, then assert req0 and req1 together -> gnt_o=001 (pointer 2 -> 0 first). Then 010.
- Async reset mid-transfer: valid_o=1, ready_i=0, assert rst_i between edges -> valid_o, gnt_o, data_o drop to 0 and select_o=2 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one Mux3to1 between three requesters and
// feeding a registered valid/ready output stage.

module Mux3to1 #(
   parameter int size = 32
) (
   input  logic [1:0]      select_i,
   input  logic [size-1:0] data0_i,
   input  logic [size-1:0] data1_i,
   input  logic [size-1:0] data2_i,
   output logic [size-1:0] data_o
);

   always_comb begin
      data_o = '0;
      case (select_i)
         2'd0:    data_o = data0_i;
         2'd1:    data_o = data1_i;
         2'd2:    data_o = data2_i;
         default: data_o = '0;
      endcase
   end

endmodule

module mux3_rr_arbiter #(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req0_i,
   input  logic            req1_i,
   input  logic            req2_i,
   input  logic [size-1:0] data0_i,
   input  logic [size-1:0] data1_i,
   input  logic [size-1:0] data2_i,
   output logic [2:0]      gnt_o,
   output logic [1:0]      select_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [size-1:0] data_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]      state;
   logic [2:0]      req;
   logic            any_req;
   logic [1:0]      winner;
   logic            capture;
   logic [size-1:0] mux_data;

   assign req     = {req2_i, req1_i, req0_i};
   assign any_req = |req;
   assign capture = any_req && ((state == IDLE) || ready_i);

   // Search starts just after the last granted index and wraps mod 3.
   always_comb begin
      winner = 2'd0;
      case (select_o)
         2'd0: begin
            if (req[1])      winner = 2'd1;
            else if (req[2]) winner = 2'd2;
            else             winner = 2'd0;
         end
         2'd1: begin
            if (req[2])      winner = 2'd2;
            else if (req[0]) winner = 2'd0;
            else             winner = 2'd1;
         end
         default: begin
            if (req[0])      winner = 2'd0;
            else if (req[1]) winner = 2'd1;
            else             winner = 2'd2;
         end
      endcase
   end

   Mux3to1 #(.size(size)) u_mux (
      .select_i (winner),
      .data0_i  (data0_i),
      .data1_i  (data1_i),
      .data2_i  (data2_i),
      .data_o   (mux_data)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         valid_o  <= 1'b0;
         data_o   <= '0;
         gnt_o    <= 3'b000;
         select_o <= 2'd2;
      end else begin
         gnt_o <= 3'b000;
         if (capture) begin
            data_o   <= mux_data;
            valid_o  <= 1'b1;
            select_o <= winner;
            gnt_o    <= 3'b001 << winner;
            state    <= BUSY;
         end else if ((state == BUSY) && ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed table-driven bench for mux3_rr_arbiter (size=8), plus hand-written
// reset sequences.

module tb_mux3_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
   logic [7:0] data0 = '0, data1 = '0, data2 = '0;
   logic       ready = 1'b0;
   logic [2:0] gnt;
   logic [1:0] select;
   logic       valid;
   logic [7:0] data;

   int unsigned compared = 0;
   int unsigned mismatched = 0;

   typedef struct {
      logic [2:0] req;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] d2;
      logic       rdy;
      logic [2:0] gnt;
      logic [1:0] sel;
      logic       v;
      logic [7:0] dat;
   } vec_t;

   localparam int unsigned NV = 22;
   vec_t tbl [NV];

   mux3_rr_arbiter #(.size(8)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req0_i   (req0),
      .req1_i   (req1),
      .req2_i   (req2),
      .data0_i  (data0),
      .data1_i  (data1),
      .data2_i  (data2),
      .gnt_o    (gnt),
      .select_o (select),
      .valid_o  (valid),
      .ready_i  (ready),
      .data_o   (data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] g, input logic [1:0] s,
                            input logic v, input logic [7:0] d);
      check({tag, " gnt"}, {29'd0, gnt}, {29'd0, g});
      check({tag, " select"}, {30'd0, select}, {30'd0, s});
      check({tag, " valid"}, {31'd0, valid}, {31'd0, v});
      check({tag, " data"}, {24'd0, data}, {24'd0, d});
   endtask

   task automatic do_reset();
      {req2, req1, req0} = 3'b000;
      ready = 1'b0;
      #2 rst = 1'b1;
      #5 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Each row: inputs applied before an edge, outputs expected just after it.
      tbl[0]  = '{3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 3'b001, 2'd0, 1'b1, 8'h04};
      tbl[1]  = '{3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 3'b010, 2'd1, 1'b1, 8'h05};
      tbl[2]  = '{3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 3'b100, 2'd2, 1'b1, 8'h06};
      tbl[3]  = '{3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 3'b001, 2'd0, 1'b1, 8'h04};
      tbl[4]  = '{3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 3'b010, 2'd1, 1'b1, 8'h05};
      tbl[5]  = '{3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 3'b100, 2'd2, 1'b1, 8'h06};
      tbl[6]  = '{3'b000, 8'h04, 8'h05, 8'h06, 1'b1, 3'b000, 2'd2, 1'b0, 8'h06};
      tbl[7]  = '{3'b000, 8'h04, 8'h05, 8'h06, 1'b1, 3'b000, 2'd2, 1'b0, 8'h06};
      tbl[8]  = '{3'b011, 8'h04, 8'h05, 8'h06, 1'b1, 3'b001, 2'd0, 1'b1, 8'h04};
      tbl[9]  = '{3'b010, 8'h04, 8'h05, 8'h06, 1'b1, 3'b010, 2'd1, 1'b1, 8'h05};
      tbl[10] = '{3'b000, 8'h04, 8'h05, 8'h06, 1'b1, 3'b000, 2'd1, 1'b0, 8'h05};
      tbl[11] = '{3'b010, 8'h04, 8'h5A, 8'h06, 1'b1, 3'b010, 2'd1, 1'b1, 8'h5A};
      tbl[12] = '{3'b000, 8'h04, 8'h5A, 8'h06, 1'b1, 3'b000, 2'd1, 1'b0, 8'h5A};
      tbl[13] = '{3'b100, 8'h04, 8'h05, 8'h06, 1'b1, 3'b100, 2'd2, 1'b1, 8'h06};
      tbl[14] = '{3'b000, 8'h04, 8'h05, 8'h06, 1'b1, 3'b000, 2'd2, 1'b0, 8'h06};
      tbl[15] = '{3'b101, 8'h04, 8'h05, 8'h06, 1'b0, 3'b001, 2'd0, 1'b1, 8'h04};
      tbl[16] = '{3'b101, 8'h04, 8'h05, 8'h06, 1'b0, 3'b000, 2'd0, 1'b1, 8'h04};
      tbl[17] = '{3'b101, 8'h04, 8'h05, 8'h06, 1'b0, 3'b000, 2'd0, 1'b1, 8'h04};
      tbl[18] = '{3'b101, 8'h04, 8'h05, 8'h06, 1'b0, 3'b000, 2'd0, 1'b1, 8'h04};
      tbl[19] = '{3'b101, 8'h04, 8'h05, 8'h06, 1'b0, 3'b000, 2'd0, 1'b1, 8'h04};
      tbl[20] = '{3'b101, 8'h04, 8'h05, 8'h06, 1'b1, 3'b100, 2'd2, 1'b1, 8'h06};
      tbl[21] = '{3'b000, 8'h04, 8'h05, 8'h06, 1'b1, 3'b000, 2'd2, 1'b0, 8'h06};

      // Reset then idle for 5 cycles.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
      end
      check_all("idle_after_reset", 3'b000, 2'd2, 1'b0, 8'h00);

      for (int i = 0; i < int'(NV); i++) begin
         {req2, req1, req0} = tbl[i].req;
         data0 = tbl[i].d0;
         data1 = tbl[i].d1;
         data2 = tbl[i].d2;
         ready = tbl[i].rdy;
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].v, tbl[i].dat);
      end

      // Asynchronous reset between edges while a word is pending.
      do_reset();
      data0 = 8'hC3;
      ready = 1'b0;
      req0  = 1'b1;
      @(posedge clk);
      #1;
      check_all("pre_async_reset", 3'b001, 2'd0, 1'b1, 8'hC3);
      req0 = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_all("async_reset", 3'b000, 2'd2, 1'b0, 8'h00);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check_all("after_async_reset", 3'b000, 2'd2, 1'b0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
